// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: idle fill, 0x7E flags, zero insertion and abort pattern.
// Defining HDLC_TX_FCS_EN appends a CRC-16/X.25 FCS after the payload.
`timescale 1ns/1ps
module hdlc_tx_framer #(
    parameter int MAX_BYTES = 128,
    parameter int IDLE_MIN  = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_Last,
    output logic       Tx_DataReady,
    input  logic       Tx_AbortReq,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done,
    output logic [7:0] Tx_FrameSize,
    output logic       Tx_Busy
);
    localparam int IW = $clog2(IDLE_MIN + 1);
    localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MIN);

`ifdef HDLC_TX_FCS_EN
    typedef enum logic [2:0] {IDLE, START, DATA, ENDF, ABORT, FCS} state_t;
    localparam state_t AFTER_DATA = FCS;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, ENDF, ABORT} state_t;
    localparam state_t AFTER_DATA = ENDF;
`endif

    state_t        state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    cur, cur_n;
    logic [4:0]    nidx, nidx_n;
    logic [2:0]    ones, ones_n;
    logic          last, last_n, over, over_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic          tx_n, valid_n, ready_n, abrt_n, done_n;
    logic [7:0]    size_n;
    logic          hs, underrun, stuff, data_end, oversize, bit_out;
    logic [7:0]    byte_src;
    logic [4:0]    idx_src;
`ifdef HDLC_TX_FCS_EN
    logic [15:0]   crc, crc_n;
`endif

    // nidx is the index of the next data bit to send; 8 means the byte is exhausted
    assign hs       = Tx_DataReady && Tx_DataValid;
    assign underrun = Tx_DataReady && !Tx_DataValid;
    assign stuff    = (ones == 3'd5);
    assign data_end = last && (nidx == 5'd8) && !stuff;
    assign oversize = hs && !Tx_Last && (({1'b0, Tx_FrameSize} + 9'd1) == 9'(MAX_BYTES));
    assign byte_src = hs ? Tx_Data : cur;
    assign idx_src  = hs ? 5'd0 : nidx;
    assign bit_out  = byte_src[idx_src[2:0]];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            cnt             <= '0;
            cur             <= '0;
            nidx            <= '0;
            ones            <= '0;
            last            <= 1'b0;
            over            <= 1'b0;
            idle_cnt        <= IDLE_SAT;
            Tx              <= 1'b1;
            Tx_DataReady    <= 1'b0;
            Tx_ValidFrame   <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_FrameSize    <= '0;
            Tx_Busy         <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            crc             <= 16'hFFFF;
`endif
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            cur             <= cur_n;
            nidx            <= nidx_n;
            ones            <= ones_n;
            last            <= last_n;
            over            <= over_n;
            idle_cnt        <= idle_n;
            Tx              <= tx_n;
            Tx_DataReady    <= ready_n;
            Tx_ValidFrame   <= valid_n;
            Tx_AbortedTrans <= abrt_n;
            Tx_Done         <= done_n;
            Tx_FrameSize    <= size_n;
            Tx_Busy         <= (state_n != IDLE);
`ifdef HDLC_TX_FCS_EN
            crc             <= crc_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (Tx_Enable && Tx_DataValid && idle_cnt == IDLE_SAT) state_n = START;
            end
            START: begin
                if (Tx_AbortReq) state_n = ABORT;
                else if (cnt == 3'd7) state_n = hs ? DATA : ABORT;
            end
            DATA: begin
                if (Tx_AbortReq || underrun) state_n = ABORT;
                else if (data_end) state_n = over ? ABORT : AFTER_DATA;
            end
`ifdef HDLC_TX_FCS_EN
            FCS: begin
                if (Tx_AbortReq) state_n = ABORT;
                else if (nidx == 5'd16 && !stuff) state_n = ENDF;
            end
`endif
            ENDF, ABORT: begin
                if (cnt == 3'd7) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Computes the bit and flags that go on the line in the next cycle
    always_comb begin
        cnt_n   = cnt + 3'd1;
        cur_n   = cur;
        nidx_n  = nidx;
        ones_n  = ones;
        last_n  = last;
        over_n  = over;
        idle_n  = idle_cnt;
        size_n  = Tx_FrameSize;
        tx_n    = 1'b1;
        valid_n = 1'b0;
        ready_n = 1'b0;
        abrt_n  = 1'b0;
        done_n  = 1'b0;
`ifdef HDLC_TX_FCS_EN
        crc_n   = crc;
`endif
        case (state_n)
            IDLE: begin
                cnt_n = '0;
                if (state != IDLE) idle_n = '0;
                else if (idle_cnt != IDLE_SAT) idle_n = idle_cnt + 1'b1;
            end
            START: begin
                valid_n = 1'b1;
                if (state == IDLE) begin
                    cnt_n  = '0;
                    size_n = '0;
                    nidx_n = 5'd8;
                    ones_n = '0;
                    last_n = 1'b0;
                    over_n = 1'b0;
`ifdef HDLC_TX_FCS_EN
                    crc_n  = 16'hFFFF;
`endif
                end
                tx_n    = (cnt_n != 3'd0) && (cnt_n != 3'd7);
                ready_n = (cnt_n == 3'd7);
            end
            DATA: begin
                valid_n = 1'b1;
                if (hs) begin
                    cur_n  = Tx_Data;
                    size_n = Tx_FrameSize + 8'd1;
                    last_n = Tx_Last || oversize;
                    over_n = oversize;
                end
                if (stuff) begin
                    tx_n   = 1'b0;
                    ones_n = '0;
                    nidx_n = idx_src;
                end else begin
                    tx_n    = bit_out;
                    ones_n  = bit_out ? ones + 3'd1 : 3'd0;
                    nidx_n  = idx_src + 5'd1;
                    ready_n = (idx_src == 5'd7) && !last_n;
`ifdef HDLC_TX_FCS_EN
                    crc_n   = {1'b0, crc[15:1]} ^ ((crc[0] ^ bit_out) ? 16'h8408 : 16'h0000);
`endif
                end
            end
`ifdef HDLC_TX_FCS_EN
            FCS: begin
                valid_n = 1'b1;
                if (state == FCS && stuff) begin
                    tx_n   = 1'b0;
                    ones_n = '0;
                end else begin
                    tx_n   = ~crc[0];
                    ones_n = ~crc[0] ? ones + 3'd1 : 3'd0;
                    crc_n  = {1'b0, crc[15:1]};
                    nidx_n = ((state == FCS) ? nidx : 5'd0) + 5'd1;
                end
            end
`endif
            ENDF: begin
                if (state != ENDF) cnt_n = '0;
                tx_n   = (cnt_n != 3'd0) && (cnt_n != 3'd7);
                done_n = (cnt_n == 3'd7);
            end
            ABORT: begin
                if (state != ABORT) cnt_n = '0;
                abrt_n = (state != ABORT);
                tx_n   = (cnt_n != 3'd0);
            end
            default: ;
        endcase
    end
endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Serial HDLC transmit framer that completes the Rx datapath on the transmit side. Takes bytes over a valid/ready handshake and drives a one-bit-per-clock line. Generates the idle pattern, start and end flags (0x7E), zero insertion and the abort pattern. Optionally appends a CRC-16 FCS. Sits between the Tx buffer/control register logic and the Tx pin.

Parameters:
MAX_BYTES, 128, maximum payload bytes per frame; exceeding it aborts the frame
IDLE_MIN, 8, minimum idle (1) bits driven between end of one frame/abort and the next start flag

Ports:
Clk  input  1  system clock, one line bit per cycle
Rst  input  1  reset, asynchronous, active-high
Tx_Enable  input  1  allows a new frame to start; does not affect a frame in progress
Tx_Data  input  8  payload byte, sent LSB first
Tx_DataValid  input  1  Tx_Data is valid
Tx_Last  input  1  qualifies Tx_Data as final byte of the frame
Tx_DataReady  output  1  byte accepted this cycle when Tx_DataValid is also high
Tx_AbortReq  input  1  request to abort the current frame
Tx  output  1  serial line
Tx_ValidFrame  output  1  high during start flag, data and FCS; low from the first end-flag bit
Tx_AbortedTrans  output  1  one-cycle pulse when a frame is aborted
Tx_Done  output  1  one-cycle pulse on the last end-flag bit
Tx_FrameSize  output  8  bytes accepted in current/last frame
Tx_Busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is asynchronous and active-high.
- Reset values: Tx=1; all other outputs 0; state IDLE; idle counter saturated (start allowed immediately).
- All outputs are registered. Tx changes at most once per Clk.
- IDLE:
  - Tx=1; idle counter counts up to IDLE_MIN.
  - If Tx_Enable && Tx_DataValid && idle counter==IDLE_MIN at cycle t, go to START_FLAG. Tx_FrameSize clears to 0.
- START_FLAG:
  - Bits 0,1,1,1,1,1,1,0 on Tx in cycles t+1..t+8. Tx_ValidFrame=1 from t+1.
  - Tx_DataReady=1 at t+8. First data bit appears at t+9.
- DATA:
  - Shift byte LSB first. A ones-run counter counts consecutive 1 data bits and is cleared by any 0.
  - After five 1s, insert a 0 (stuff bit) and clear the counter. The counter persists across byte boundaries. Flag and abort bits are never stuffed and do not affect the counter.
  - Tx_DataReady=1 in the cycle the 8th bit of the current byte is on Tx, unless that byte was taken with Tx_Last.
  - On handshake, load the new byte. If a stuff bit is pending, it is sent before the new byte's bit 0.
  - Tx_FrameSize increments on each accepted byte.
  - Underrun: Tx_DataReady=1 with Tx_DataValid=0 -> ABORT next cycle.
  - Oversize: byte number MAX_BYTES accepted with Tx_Last=0 -> that byte is sent (plus any stuff bit), then ABORT.
  - After the final bit of the Tx_Last byte and any pending stuff bit -> FCS (if enabled) else END_FLAG.
- END_FLAG:
  - Tx_ValidFrame=0; sends 0,1,1,1,1,1,1,0.
  - Tx_Done=1 on the final 0; then IDLE with idle counter cleared.
- ABORT:
  - Entered the cycle after the cause (Tx_AbortReq in START_FLAG/DATA/FCS, underrun, or oversize).
  - Tx_AbortedTrans=1 on entry cycle only. Tx_ValidFrame=0.
  - Tx sends 0 then seven 1s (8 cycles); then IDLE with idle counter cleared.
  - Any in-progress byte is discarded. Tx_DataReady=0 throughout.
- Priorities and ignored requests:
  - Tx_AbortReq in IDLE, END_FLAG or ABORT is ignored.
  - Abort beats a simultaneous Tx_Last handshake or FCS completion.
  - Tx_Enable falling mid-frame has no effect.
- Reset mid-frame: Tx returns to 1 immediately and asynchronously. No abort pulse; no Tx_Done.

Optional Feature:
- Macro: HDLC_TX_FCS_EN.
- Defined:
  - CRC-16/X.25: poly x^16+x^12+x^5+1, reflected, init 0xFFFF, computed over unstuffed data bits.
  - FCS state sends the complemented CRC, 16 bits, LSB first, with zero insertion applied. Tx_ValidFrame stays 1 during FCS.
  - Abort during FCS is honoured.
- Undefined: no FCS state and no CRC logic; END_FLAG follows data directly.

Test Plan:
- Single byte 0x00, Tx_Last=1, FCS off, Tx_DataValid at t:
  - Tx t+1..t+24 = 01111110 00000000 01111110.
  - Tx_Done at t+24; Tx_FrameSize=1; Tx=1 afterwards.
- Byte 0xFF then 0x01 (last), FCS off:
  - Data bits on line = 11111 0 111 1 0000000 (one stuff bit, run carried across the byte boundary).
  - Frame is 33 cycles long, flags included.
- Tx_AbortReq pulsed during 2nd bit of byte 3 of a 5-byte frame:
  - Next cycle Tx_AbortedTrans=1, Tx=0 then 1111111.
  - Tx_Done never pulses; next start no earlier than IDLE_MIN cycles after abort end.
- Underrun: deassert Tx_DataValid before 2nd byte request -> ABORT entered the cycle after the Tx_DataReady cycle; Tx_FrameSize=1.
- Oversize: 129 bytes with Tx_Last never set, MAX_BYTES=128 -> 128 bytes transmitted, then abort pattern, Tx_FrameSize=128.
- HDLC_TX_FCS_EN defined, payload ASCII "123456789" -> FCS bytes on line 0x6E then 0x90 (LSB first, stuffed as needed), then end flag. Also assert Rst mid-frame -> Tx=1 the same cycle, state IDLE.
